// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_divider.sv
// Restoring divider on operand magnitudes; exposes the sign-corrected result of the current step.
module mult_div_divider #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic                    step,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic signed [WIDTH-1:0] quo_next,
  output logic signed [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             quo_neg, rem_neg;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_n, quo_n;

  // The partial remainder is always below the divisor magnitude, so WIDTH bits hold it.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    fits    = !trial[WIDTH];
    rem_n   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_n   = {quo_q[WIDTH-2:0], fits};
  end

  assign quo_next = quo_neg ? -quo_n : quo_n;
  assign rem_next = rem_neg ? -rem_n : rem_n;

  always_ff @(posedge clk) begin
    if (load) begin
      rem_q   <= '0;
      quo_q   <= dividend[WIDTH-1] ? WIDTH'(-dividend) : WIDTH'(dividend);
      dvs_q   <= divisor[WIDTH-1]  ? WIDTH'(-divisor)  : WIDTH'(divisor);
      quo_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rem_neg <= dividend[WIDTH-1];
    end else if (step) begin
      rem_q   <= rem_n;
      quo_q   <= quo_n;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with {hi,lo} result registers.
// Divide path is built only when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    last_iter;
  logic signed [WIDTH:0]   acc, mcand, sum, acc_n;
  logic [WIDTH-1:0]        mq, mq_n;
  logic                    q1;

  assign last_iter = (cnt == LAST);

  // One extra accumulator bit keeps acc - mcand in range when mcand is the most negative value.
  always_comb begin
    sum = acc;
    case ({mq[0], q1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_n = sum >>> 1;
    mq_n  = {sum[0], mq[WIDTH-1:1]};
  end

`ifdef MULT_DIV_UNIT_DIV_EN
  logic                    div_by_zero;
  logic signed [WIDTH-1:0] quo_next, rem_next;

  assign div_by_zero = (op_b == '0);

  mult_div_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (clk),
    .load     (state == IDLE),
    .step     (state == DIV),
    .dividend (op_a),
    .divisor  (op_b),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );
`else
  logic unused_div_start;
  assign unused_div_start = div_start;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_start) begin
            acc      <= '0;
            mcand    <= {op_b[WIDTH-1], op_b};
            mq       <= op_a;
            q1       <= 1'b0;
            cnt      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= MULT;
          end
`ifdef MULT_DIV_UNIT_DIV_EN
          else if (div_start) begin
            cnt      <= '0;
            busy     <= 1'b1;
            div_zero <= div_by_zero;
            if (div_by_zero) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
`endif
        end
        MULT: begin
          acc <= acc_n;
          mq  <= mq_n;
          q1  <= mq[0];
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi    <= acc_n[WIDTH-1:0];
            lo    <= mq_n;
            done  <= 1'b1;
            state <= DONE;
          end
        end
`ifdef MULT_DIV_UNIT_DIV_EN
        DIV: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi    <= rem_next;
            lo    <= quo_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops against a plain-arithmetic model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, mult_start, div_start;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Issue one start at a negedge, then watch up to 40 cycles for done; lat = -1 if none.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] rh, output logic [31:0] rl,
                       output logic rdz);
    @(negedge clk);
    mult_start = m; div_start = d; op_a = a; op_b = b;
    lat = -1; rh = hi; rl = lo; rdz = div_zero;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      mult_start = 1'b0; div_start = 1'b0;
      if (done === 1'b1) begin lat = n; rh = hi; rl = lo; rdz = div_zero; end
    end
    if (lat < 0) begin rh = hi; rl = lo; rdz = div_zero; end
  endtask

  task automatic test_reset();
    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_mult_directed();
    int lat; logic [31:0] rh, rl; logic rdz;
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, rh, rl, rdz);
    checks++; if (lat != 33) begin errors++; $display("FAIL mul7x-3_latency: got %0d want 33", lat); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul7x-3_hi: got %h want ffffffff", rh); end
    checks++; if (rl !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul7x-3_lo: got %h want ffffffeb", rl); end
    checks++; if (rdz !== 1'b0) begin errors++; $display("FAIL mul7x-3_div_zero: got %b want 0", rdz); end
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, rh, rl, rdz);
    checks++; if (rh !== 32'h4000_0000) begin errors++; $display("FAIL mulmin_hi: got %h want 40000000", rh); end
    checks++; if (rl !== 32'h0) begin errors++; $display("FAIL mulmin_lo: got %h want 0", rl); end
    do_op(1'b1, 1'b0, 32'd6, 32'd715827883, lat, rh, rl, rdz);
    checks++; if (rh !== 32'h1 || rl !== 32'h2) begin errors++; $display("FAIL mul_hi1lo2: got %h_%h want 00000001_00000002", rh, rl); end
    exp_hi = 32'h1; exp_lo = 32'h2;
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] rh, rl; logic rdz;
    do_op(1'b0, 1'b1, 32'd5, 32'd0, lat, rh, rl, rdz);
`ifdef MULT_DIV_UNIT_DIV_EN
    checks++; if (lat != 1) begin errors++; $display("FAIL divzero_latency: got %0d want 1", lat); end
    checks++; if (rdz !== 1'b1) begin errors++; $display("FAIL divzero_flag: got %b want 1", rdz); end
    checks++; if (rh !== exp_hi || rl !== exp_lo) begin errors++; $display("FAIL divzero_hold: got %h_%h want %h_%h", rh, rl, exp_hi, exp_lo); end
    repeat (3) @(negedge clk);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divzero_sticky: got %b want 1", div_zero); end
`else
    checks++; if (lat != -1) begin errors++; $display("FAIL nodiv_done: got latency %0d want none", lat); end
    checks++; if (rdz !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nodiv_flags: got dz=%b busy=%b want 0 0", rdz, busy); end
    checks++; if (rh !== exp_hi || rl !== exp_lo) begin errors++; $display("FAIL nodiv_hold: got %h_%h want %h_%h", rh, rl, exp_hi, exp_lo); end
`endif
    do_op(1'b1, 1'b0, 32'd2, 32'd3, lat, rh, rl, rdz);
    checks++; if (rdz !== 1'b0 || rl !== 32'd6) begin errors++; $display("FAIL divzero_clear: got dz=%b lo=%h want 0 6", rdz, rl); end
    exp_hi = 32'h0; exp_lo = 32'd6;
  endtask

  task automatic test_div_directed();
`ifdef MULT_DIV_UNIT_DIV_EN
    int lat; logic [31:0] rh, rl; logic rdz;
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, rh, rl, rdz);
    checks++; if (lat != 33) begin errors++; $display("FAIL div-7/2_latency: got %0d want 33", lat); end
    checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div-7/2_lo: got %h want fffffffd", rl); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div-7/2_hi: got %h want ffffffff", rh); end
    checks++; if (rdz !== 1'b0) begin errors++; $display("FAIL div-7/2_div_zero: got %b want 0", rdz); end
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, rh, rl, rdz);
    checks++; if (rl !== 32'hFFFF_FFFD || rh !== 32'h1) begin errors++; $display("FAIL div7/-2: got %h_%h want 00000001_fffffffd", rh, rl); end
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, rh, rl, rdz);
    checks++; if (rl !== 32'h8000_0000 || rh !== 32'h0 || rdz !== 1'b0) begin errors++; $display("FAIL divwrap: got %h_%h dz=%b want 00000000_80000000 dz=0", rh, rl, rdz); end
    exp_hi = rh; exp_lo = rl;
    if (rl === 32'h8000_0000 && rh === 32'h0) begin exp_hi = 32'h0; exp_lo = 32'h8000_0000; end
`endif
  endtask

  task automatic test_collision();
    logic [31:0] a1, b1, a2, b2, rh, rl;
    logic [63:0] p;
    logic        busy_after;
    int          pulses, first, busy_bad;
    pulses = 0; first = -1; busy_bad = 0; rh = '0; rl = '0; busy_after = 1'bx;
    a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
    p = ref_mul(a1, b1);
    @(negedge clk);
    mult_start = 1'b1; div_start = 1'b1; op_a = a1; op_b = b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      mult_start = (n == 5); div_start = 1'b0;
      if (n == 5) begin op_a = a2; op_b = b2; end
      if (done === 1'b1) begin pulses++; if (first < 0) begin first = n; rh = hi; rl = lo; end end
      if (n <= 33 && busy !== 1'b1) busy_bad++;
      if (n == 34) busy_after = busy;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL collide_pulses: got %0d want 1", pulses); end
    checks++; if (first != 33) begin errors++; $display("FAIL collide_latency: got %0d want 33", first); end
    checks++; if ({rh, rl} !== p) begin errors++; $display("FAIL collide_product: got %h%h want %h", rh, rl, p); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL collide_busy: got %0d low cycles want 0", busy_bad); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL collide_idle: got busy=%b want 0", busy_after); end
    exp_hi = p[63:32]; exp_lo = p[31:0];
  endtask

  task automatic test_done_ignore();
    int lat, pulses; logic [31:0] rh, rl; logic rdz;
    pulses = 0;
    do_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFB, lat, rh, rl, rdz);
    mult_start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    mult_start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_busy: got %b want 0", busy); end
    for (int n = 0; n < 38; n++) begin @(negedge clk); if (done === 1'b1) pulses++; end
    checks++; if (pulses != 0 || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL done_start_ignored: got pulses=%0d lo=%h want 0 fffffff1", pulses, lo); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
  endtask

  task automatic test_reset_mid();
    int pulses; logic busy_r;
    pulses = 0;
    @(negedge clk);
    mult_start = 1'b1; op_a = $urandom(); op_b = $urandom();
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      mult_start = 1'b0;
      reset = (n == 10);
      if (n == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h_%h want 0_0", hi, lo); end
      end
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses want 0", pulses); end
    @(negedge clk);
    reset = 1'b1; mult_start = 1'b1; op_a = 32'd4; op_b = 32'd4;
    @(negedge clk);
    reset = 1'b0; mult_start = 1'b0;
    busy_r = busy;
    pulses = 0;
    for (int n = 0; n < 38; n++) begin @(negedge clk); if (done === 1'b1) pulses++; end
    checks++; if (busy_r !== 1'b0 || pulses != 0) begin errors++; $display("FAIL rst_vs_start: got busy=%b pulses=%0d want 0 0", busy_r, pulses); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [31:0] a, b, rh, rl, q, r; logic rdz, exp_dz, is_div;
    logic [63:0] p;
    for (int i = 0; i < 30; i++) begin
      is_div = ($urandom_range(0, 1) == 1);
      a = pick(); b = pick();
      if (is_div && $urandom_range(0, 7) == 0) b = 32'h0;
      if (!is_div) begin
        p = ref_mul(a, b); exp_hi = p[63:32]; exp_lo = p[31:0]; exp_lat = 33; exp_dz = 1'b0;
      end else begin
`ifdef MULT_DIV_UNIT_DIV_EN
        if (b == 32'h0) begin exp_lat = 1; exp_dz = 1'b1; end
        else begin ref_div(a, b, q, r); exp_hi = r; exp_lo = q; exp_lat = 33; exp_dz = 1'b0; end
`else
        q = '0; r = '0; exp_lat = -1; exp_dz = 1'b0;
`endif
      end
      do_op(!is_div, is_div, a, b, lat, rh, rl, rdz);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency: op %0s a=%h b=%h got %0d want %0d", i, is_div ? "div" : "mul", a, b, lat, exp_lat); end
      checks++; if (rh !== exp_hi) begin errors++; $display("FAIL rand%0d_hi: op %0s a=%h b=%h got %h want %h", i, is_div ? "div" : "mul", a, b, rh, exp_hi); end
      checks++; if (rl !== exp_lo) begin errors++; $display("FAIL rand%0d_lo: op %0s a=%h b=%h got %h want %h", i, is_div ? "div" : "mul", a, b, rl, exp_lo); end
      checks++; if (rdz !== exp_dz) begin errors++; $display("FAIL rand%0d_div_zero: got %b want %b", i, rdz, exp_dz); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_zero();
    test_div_directed();
    test_collision();
    test_done_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port mult_start, input, 1: request a signed multiply of op_a by op_b.
REQ-005 SHALL have port div_start, input, 1: request a signed divide, op_a divided by op_b.
REQ-006 SHALL have ports op_a and op_b, input, WIDTH each: operands, sampled only on the accepted start cycle.
REQ-007 SHALL have port busy, output, 1: operation in progress (state not IDLE).
REQ-008 SHALL have port done, output, 1: one-cycle pulse; hi and lo are valid in that cycle.
REQ-009 SHALL have port div_zero, output, 1: last accepted divide had op_b equal to 0.
REQ-010 SHALL have ports hi and lo, output, WIDTH each: result registers that feed the downstream 8-input source mux.

Function
REQ-011 SHALL implement states IDLE, MULT, DIV and DONE; any unreachable encoding SHALL return to IDLE.
REQ-012 SHALL accept a start only in IDLE; starts asserted in any other state SHALL be ignored.
REQ-013 If mult_start and div_start are both high in IDLE, multiply SHALL win and div_start SHALL be dropped.
REQ-014 Multiply SHALL use radix-2 Booth, one iteration per cycle, WIDTH cycles in MULT, then one cycle in DONE.
REQ-015 Multiply SHALL place the product in {hi,lo} as signed 2*WIDTH bits, with done high exactly WIDTH+1 cycles after the start edge.
REQ-016 Divide SHALL use restoring division on operand magnitudes with sign fix-up, WIDTH cycles in DIV, then DONE; its latency SHALL equal multiply latency.
REQ-017 Divide results SHALL be: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-018 Divide of -2^(WIDTH-1) by -1 SHALL give lo = 0x80000000 and hi = 0 (two's-complement wrap), with no flag raised.
REQ-019 Divide with op_b = 0 SHALL go IDLE to DONE directly: done high one cycle after start, div_zero = 1, hi and lo unchanged.
REQ-020 div_zero SHALL hold its value until the next accepted start, which clears it or sets it.
REQ-021 hi and lo SHALL update only on entry to DONE and hold between operations.
REQ-022 DONE SHALL always advance to IDLE after one cycle; a start in the DONE cycle SHALL be ignored.

Reset
REQ-023 On reset SHALL force state IDLE, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, and clear internal counters.
REQ-024 Reset mid-operation SHALL abort with no done pulse; reset has priority over any start in the same cycle.

Configuration
REQ-025 Macro MULT_DIV_UNIT_DIV_EN defined: divide path present as specified above.
REQ-026 Macro MULT_DIV_UNIT_DIV_EN undefined: DIV state and divider logic absent; div_start ignored; div_zero tied to 0; multiply behaviour and latency unchanged.

Structure
REQ-027 Package mult_div_pkg SHALL hold the state enum, the WIDTH default constant and the iteration-counter width constant.
REQ-028 The restoring divider datapath SHALL be the sub-module mult_div_divider, instantiated only under MULT_DIV_UNIT_DIV_EN.

Verification
REQ-029 mult 7 x -3 -> done at start+33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-030 mult 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-031 div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, div_zero = 0, done at start+33.
REQ-032 div 5 / 0 with prior hi = 1, lo = 2 -> done at start+1, div_zero = 1, hi = 1, lo = 2 held.
REQ-033 mult_start and div_start high together, then mult_start re-pulsed at cycle 5 -> single multiply result, the cycle-5 start ignored, busy high through DONE.
REQ-034 reset at cycle 10 of a multiply -> next cycle busy = 0, hi = lo = 0, and no done pulse.
